axi_hp_traffic_gen: RTL
=======================

Name: axi_hp_traffic_gen

Overview:
- Parametrised AXI HP traffic generator and checker for bandwidth and latency measurement on the PS HP ports.
- Writes N INCR bursts of a deterministic pattern, reads them back, or does both in sequence.
- On read-back it compares every beat and counts mismatches and bad responses.
- Sits behind a register-file wrapper that drives the config inputs and samples the status outputs; its master side connects directly to an HP slave port.

Parameters:
- DATA_W, 64: AXI data width; 32, 64 or 128.
- ADDR_W, 32: AXI address width.
- BURST_LEN, 16: beats per burst, 1..16 (AXI3). awlen/arlen = BURST_LEN-1.
- CNT_W, 16: width of the burst count and of the error counters.
- TIME_W, 32: width of the cycle timer.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- mode  in  2  00 write, 01 read, 10 write then read, 11 reserved (treated as 00).
- num_bursts  in  CNT_W  burst count; sampled at start.
- base_addr  in  ADDR_W  start address; sampled at start; must be burst-aligned.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run finishes.
- time_cnt  out  TIME_W  cycles from start to done.
- data_err  out  CNT_W  count of read beats that mismatch the pattern.
- resp_err  out  CNT_W  count of B and R responses with resp != 00.
- awaddr/awlen[3:0]/awsize[2:0]/awburst[1:0]/awvalid  out; awready  in.
- wdata[DATA_W]/wstrb[DATA_W/8]/wlast/wvalid  out; wready  in.
- bresp[1:0]/bvalid  in; bready  out, tied to 1.
- araddr/arlen/arsize/arburst/arvalid  out; arready  in.
- rdata[DATA_W]/rresp[1:0]/rlast/rvalid  in; rready  out.
- awid/wid/arid = 0; awcache/arcache = 4'b0010; awprot/arprot/awqos/arqos/awlock/arlock = 0.

Behaviour:
- Reset (resetn low, asynchronous): FSM goes to IDLE. All valids are 0, rready is 0, busy and done are 0, and every counter is 0.
- Static AXI fields: awsize = arsize = log2(DATA_W/8). awburst = arburst = 01 (INCR). wstrb is all ones.
- Burst address: address of burst n = base_addr + n*BURST_LEN*DATA_W/8, computed modulo 2^ADDR_W (wrap-around is permitted).
- Data pattern: beat index k counts from 0 over the whole run. 32-bit lane i of beat k = k[31:0] + i. The read phase restarts k at 0.
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, FIN.
- IDLE:
  - On start, latch the inputs, clear time_cnt, data_err and resp_err, and set busy on the next cycle.
  - If num_bursts == 0, go to FIN with no AXI traffic.
  - Otherwise go to W_ADDR (modes 00/10/11) or R_ADDR (mode 01).
- W_ADDR:
  - awvalid = 1 with awaddr stable until awready.
  - On handshake go to W_DATA. One burst is in flight at a time: AW is not reissued until wlast of the current burst completes.
- W_DATA:
  - wvalid = 1, and wdata holds until wready.
  - wlast is high on beat BURST_LEN-1 only; with BURST_LEN == 1, every beat is last.
  - After wlast handshake: if bursts remain go to W_ADDR, else go to W_RESP.
- W_RESP:
  - Wait until the B count equals num_bursts. bvalid is accepted in any state.
  - Then go to R_ADDR (mode 10) or FIN.
- R_ADDR: arvalid = 1 until arready, then go to R_DATA.
- R_DATA:
  - rready = 1. Each rvalid beat is compared with the expected pattern; on mismatch data_err increments.
  - rresp != 00 increments resp_err, once per beat.
  - After rlast: if bursts remain go to R_ADDR, else go to FIN.
- FIN: done = 1 for one cycle, busy = 0, return to IDLE. Counters hold until the next start.
- Error counters saturate at all ones.
- B and R error events in the same cycle increment resp_err by 2 (saturating).
- time_cnt increments every cycle while busy and saturates at all ones.
- A start pulse that arrives while busy has no effect.

Test Plan:
- DATA_W=64, BURST_LEN=16, mode 00, num_bursts=4, base 0x3FFC0000, AXI slave always ready:
  - Expect 4 AW at 0x3FFC0000/0x3FFC0080/0x3FFC0100/0x3FFC0180.
  - Expect 64 W beats; beat 17 lane0 = 0x11, lane1 = 0x12; wlast on beats 15/31/47/63.
  - Expect done once and data_err = resp_err = 0.
- Mode 10 against a memory model with random ready/valid back-pressure (50%):
  - Expect read-back of 4 bursts and data_err = 0.
  - Expect wdata/awaddr held stable during every stall.
- Mode 01 with model memory word 20 corrupted and one R beat returning SLVERR:
  - Expect data_err = 1 and resp_err = 1.
- num_bursts = 0, then start:
  - Expect done 2 cycles after start, no valid asserted, time_cnt = 1.
- Reset and start-while-busy:
  - Drop resetn mid-W_DATA: expect all valids low immediately and busy = 0; a fresh start restarts at base_addr with k = 0.
  - Pulse start while busy: expect no effect.
- BURST_LEN=1, DATA_W=128, base 0xFFFFFFF0, num_bursts=2:
  - Expect second awaddr = 0x00000000 (wrap-around) and wlast on every beat.

Source files
------------

// File: rtl/axi_hp_traffic_gen.sv
// rtl/axi_hp_traffic_gen.sv - AXI3 HP-port burst traffic generator with read-back pattern checker
// One INCR burst in flight at a time; pattern lane i of beat k is k + i.
module axi_hp_traffic_gen #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16,
  parameter int TIME_W    = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    num_bursts,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [TIME_W-1:0]   time_cnt,
  output logic [CNT_W-1:0]    data_err,
  output logic [CNT_W-1:0]    resp_err,
  output logic [5:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic                awvalid,
  input  logic                awready,
  output logic [5:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [5:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic [3:0]          arqos,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int LANES  = DATA_W / 32;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0]        AXSIZE      = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, FIN} state_t;

  state_t              state, state_nx;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    burst_cnt;
  logic [CNT_W-1:0]    b_cnt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEAT_W-1:0]   beat;
  logic [31:0]         k;
  logic [DATA_W-1:0]   pattern;

  logic                w_hs, r_hs, b_hs;
  logic                b_err, r_err, last_burst;
  logic [1:0]          resp_inc;
  logic [CNT_W:0]      resp_sum;

  assign awid    = '0;
  assign wid     = '0;
  assign arid    = '0;
  assign awlen   = 4'(BURST_LEN - 1);
  assign arlen   = 4'(BURST_LEN - 1);
  assign awsize  = AXSIZE;
  assign arsize  = AXSIZE;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign awlock  = '0;
  assign arlock  = '0;
  assign awcache = 4'b0010;
  assign arcache = 4'b0010;
  assign awprot  = '0;
  assign arprot  = '0;
  assign awqos   = '0;
  assign arqos   = '0;
  assign wstrb   = '1;
  assign bready  = 1'b1;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = pattern;
  assign wlast   = (beat == LAST_BEAT);

  // Same generator serves write data and the read-back reference.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < LANES; i++) begin
      pattern[32*i +: 32] = k + 32'(i);
    end
  end

  assign w_hs       = wvalid & wready;
  assign r_hs       = rvalid & rready;
  assign b_hs       = bvalid & bready;
  assign b_err      = b_hs && (bresp != 2'b00);
  assign r_err      = r_hs && (rresp != 2'b00);
  assign last_burst = (burst_cnt == num_q - CNT_W'(1));
  assign resp_inc   = {1'b0, b_err} + {1'b0, r_err};
  assign resp_sum   = {1'b0, resp_err} + (CNT_W+1)'(resp_inc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_bursts == '0)   state_nx = FIN;
          else if (mode == 2'b01) state_nx = R_ADDR;
          else                    state_nx = W_ADDR;
        end
      end
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nx = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) state_nx = last_burst ? W_RESP : W_ADDR;
      end
      W_RESP: begin
        if (b_cnt == num_q) state_nx = (mode_q == 2'b10) ? R_ADDR : FIN;
      end
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nx = last_burst ? FIN : R_ADDR;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      time_cnt  <= '0;
      data_err  <= '0;
      resp_err  <= '0;
      mode_q    <= '0;
      num_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      burst_cnt <= '0;
      b_cnt     <= '0;
      beat      <= '0;
      k         <= '0;
    end else begin
      done <= (state == FIN);
      if (state == IDLE && start) begin
        busy      <= 1'b1;
        time_cnt  <= '0;
        data_err  <= '0;
        resp_err  <= '0;
        mode_q    <= mode;
        num_q     <= num_bursts;
        base_q    <= base_addr;
        addr_q    <= base_addr;
        burst_cnt <= '0;
        b_cnt     <= '0;
        beat      <= '0;
        k         <= '0;
      end else begin
        if (state == FIN) busy <= 1'b0;
        if (busy && time_cnt != '1) time_cnt <= time_cnt + TIME_W'(1);
        if (b_hs) b_cnt <= b_cnt + CNT_W'(1);
        resp_err <= resp_sum[CNT_W] ? '1 : resp_sum[CNT_W-1:0];
        if (r_hs && rdata != pattern && data_err != '1) data_err <= data_err + CNT_W'(1);
        if (w_hs || r_hs) k <= k + 32'd1;
        if (w_hs) beat <= wlast ? '0 : beat + BEAT_W'(1);
        if ((w_hs && wlast) || (r_hs && rlast)) begin
          burst_cnt <= burst_cnt + CNT_W'(1);
          addr_q    <= addr_q + BURST_BYTES;
        end
        // Read-back of a write-then-read run restarts at the base with k = 0.
        if (state == W_RESP && state_nx == R_ADDR) begin
          burst_cnt <= '0;
          addr_q    <= base_q;
          k         <= '0;
        end
      end
    end
  end

endmodule
